// File: rtl/rover_pkg.sv
// Shared types for the rover drive controller: FSM state encoding, H-bridge
// input patterns and the duty saturation helper.
package rover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LOST  = 2'd2,
    BRAKE = 2'd3
  } state_e;

  localparam logic [1:0] IN_FWD   = 2'b10;
  localparam logic [1:0] IN_BRAKE = 2'b11;
  localparam logic [1:0] IN_COAST = 2'b00;

  // Clamp a signed value into the unsigned duty range [0, 2**bits-1]
  function automatic logic [31:0] sat_duty(input logic signed [31:0] val, input int bits);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< bits) - 32'sd1;
    if (val < 32'sd0) begin
      return 32'd0;
    end else if (val > max_v) begin
      return max_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/rover_drive_ctrl_if.sv
// Sensor-side inputs and H-bridge-side outputs of the rover drive controller.
interface rover_drive_ctrl_if #(
  parameter int N_CH    = 2,
  parameter int SENSE_W = 3
);
  logic                enable;
  logic [SENSE_W-1:0]  induct;
  logic                proxim;
  logic [2*N_CH-1:0]   motor_in;
  logic [N_CH-1:0]     motor_en;
  logic [1:0]          state;

  modport master (output enable, induct, proxim, input motor_in, motor_en, state);
  modport slave  (input enable, induct, proxim, output motor_in, motor_en, state);
endinterface

// File: rtl/pwm_ramp_ch.sv
// One motor channel: duty register slewing toward its target on ramp ticks,
// plus the registered PWM compare driving the bridge enable pin.
module pwm_ramp_ch #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                clr_i,
  input  logic [PWM_BITS-1:0] target_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                en_o
);
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(RAMP_STEP);

  logic [PWM_BITS-1:0] duty_q, duty_d, gap_s, step_s;
  logic                en_q, en_d;

  // Slew-limited duty update; a clear wins over a coincident tick
  always_comb begin
    gap_s  = (target_i >= duty_q) ? (target_i - duty_q) : (duty_q - target_i);
    step_s = (gap_s < STEP_V) ? gap_s : STEP_V;
    if (clr_i) begin
      duty_d = {PWM_BITS{1'b0}};
    end else if (!tick_i) begin
      duty_d = duty_q;
    end else if (target_i >= duty_q) begin
      duty_d = duty_q + step_s;
    end else begin
      duty_d = duty_q - step_s;
    end
    en_d = !clr_i && (pwm_cnt_i < duty_q);
  end

  // Duty and enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= {PWM_BITS{1'b0}};
      en_q   <= 1'b0;
    end else begin
      duty_q <= duty_d;
      en_q   <= en_d;
    end
  end

  assign duty_o = duty_q;
  assign en_o   = en_q;
endmodule

// File: rtl/rover_drive_ctrl.sv
// Line-following drive controller for N_CH H-bridge channels: steering from the
// inductance code, slew-limited PWM duty and proximity hard-brake.
module rover_drive_ctrl
  import rover_pkg::*;
#(
  parameter int              N_CH      = 2,
  parameter logic [N_CH-1:0] SIDE_MASK = 2'b10,
  parameter int              SENSE_W   = 3,
  parameter int              PWM_BITS  = 8,
  parameter int              BASE_DUTY = 160,
  parameter int              GAIN      = 24,
  parameter int              RAMP_DIV  = 1000,
  parameter int              RAMP_STEP = 8,
  parameter int              BRAKE_CYC = 50000
) (
  input logic               clk,
  input logic               rst_n,
  rover_drive_ctrl_if.slave io
);
  localparam int TW    = PWM_BITS + SENSE_W + 2;
  localparam int PRE_W = $clog2(RAMP_DIV + 1);
  localparam int BRK_W = $clog2(BRAKE_CYC + 1);
  localparam logic [SENSE_W:0]      CENTER   = (SENSE_W + 1)'(2 ** (SENSE_W - 1));
  localparam logic signed [TW-1:0]  BASE_T   = TW'(BASE_DUTY);
  localparam logic signed [TW-1:0]  GAIN_T   = TW'(GAIN);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [BRK_W-1:0]      BRK_LOAD = BRK_W'(BRAKE_CYC - 1);

  state_e                state_q, state_d;
  logic [SENSE_W-1:0]    induct_q;
  logic                  prox_meta_q, prox_sync_q;
  logic [PRE_W-1:0]      pre_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BRK_W-1:0]      brk_q, brk_d;
  logic [2*N_CH-1:0]     motor_in_q, motor_in_d;
  logic                  ramp_tick_s, line_s, clr_s, all_zero_s;
  logic [SENSE_W:0]      err_s;
  logic signed [TW-1:0]  err_x_s, left_s, right_s;
  logic [PWM_BITS-1:0]   left_t_s, right_t_s;
  logic [PWM_BITS-1:0]   tgt_s  [N_CH];
  logic [PWM_BITS-1:0]   duty_s [N_CH];
  logic [N_CH-1:0]       en_s;

  assign ramp_tick_s = (pre_q == PRE_LAST);
  assign line_s      = (induct_q != {SENSE_W{1'b0}});

  // Input conditioning, ramp prescaler and free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      induct_q    <= {SENSE_W{1'b0}};
      prox_meta_q <= 1'b0;
      prox_sync_q <= 1'b0;
      pre_q       <= {PRE_W{1'b0}};
      pwm_cnt_q   <= {PWM_BITS{1'b0}};
    end else begin
      induct_q    <= io.induct;
      prox_meta_q <= io.proxim;
      prox_sync_q <= prox_meta_q;
      pre_q       <= ramp_tick_s ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // Steering error and per-side saturated targets; non-RUN states target zero
  always_comb begin
    err_s     = {1'b0, induct_q} - CENTER;
    err_x_s   = {{(TW - SENSE_W - 1){err_s[SENSE_W]}}, err_s};
    left_s    = BASE_T + err_x_s * GAIN_T;
    right_s   = BASE_T - err_x_s * GAIN_T;
    left_t_s  = PWM_BITS'(sat_duty({{(32 - TW){left_s[TW-1]}}, left_s}, PWM_BITS));
    right_t_s = PWM_BITS'(sat_duty({{(32 - TW){right_s[TW-1]}}, right_s}, PWM_BITS));
    for (int i = 0; i < N_CH; i++) begin
      if (state_q != RUN) begin
        tgt_s[i] = {PWM_BITS{1'b0}};
      end else if (SIDE_MASK[i]) begin
        tgt_s[i] = right_t_s;
      end else begin
        tgt_s[i] = left_t_s;
      end
    end
  end

  // All channels fully ramped down
  always_comb begin
    all_zero_s = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      all_zero_s = all_zero_s & (duty_s[i] == {PWM_BITS{1'b0}});
    end
  end

  // FSM state, brake counter and bridge IN pin register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      brk_q      <= {BRK_W{1'b0}};
      motor_in_q <= {(2 * N_CH){1'b0}};
    end else begin
      state_q    <= state_d;
      brk_q      <= brk_d;
      motor_in_q <= motor_in_d;
    end
  end

  // Next state; the proximity flag outranks every other condition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (prox_sync_q)                 state_d = BRAKE;
        else if (io.enable && line_s)    state_d = RUN;
        else                             state_d = IDLE;
      end
      RUN: begin
        if (prox_sync_q)                 state_d = BRAKE;
        else if (!line_s || !io.enable)  state_d = LOST;
        else                             state_d = RUN;
      end
      LOST: begin
        if (prox_sync_q)                 state_d = BRAKE;
        else if (line_s && io.enable)    state_d = RUN;
        else if (all_zero_s && !io.enable) state_d = IDLE;
        else                             state_d = LOST;
      end
      BRAKE: begin
        if (!prox_sync_q && brk_q == {BRK_W{1'b0}}) state_d = IDLE;
        else                                        state_d = BRAKE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == BRAKE && state_q != BRAKE) begin
      brk_d = BRK_LOAD;
    end else if (state_q == BRAKE && brk_q != {BRK_W{1'b0}}) begin
      brk_d = brk_q - BRK_W'(1);
    end else begin
      brk_d = brk_q;
    end
  end

  // Outputs decoded from the next state so brake reaches the pins on the entry edge
  always_comb begin
    clr_s = (state_d == BRAKE);
    case (state_d)
      IDLE:    motor_in_d = {N_CH{IN_COAST}};
      RUN:     motor_in_d = {N_CH{IN_FWD}};
      LOST:    motor_in_d = all_zero_s ? {N_CH{IN_COAST}} : {N_CH{IN_FWD}};
      BRAKE:   motor_in_d = {N_CH{IN_BRAKE}};
      default: motor_in_d = {N_CH{IN_COAST}};
    endcase
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_ramp_ch #(
      .PWM_BITS  (PWM_BITS),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (ramp_tick_s),
      .clr_i     (clr_s),
      .target_i  (tgt_s[g]),
      .pwm_cnt_i (pwm_cnt_q),
      .duty_o    (duty_s[g]),
      .en_o      (en_s[g])
    );
  end

  assign io.motor_in = motor_in_q;
  assign io.motor_en = en_s;
  assign io.state    = state_q;
endmodule

// File: tb/tb_rover_drive_ctrl.sv
// Directed plus randomized bench for rover_drive_ctrl; a 2-channel and a 4-channel
// instance share stimulus and are checked against a tick-level duty model.
module tb_rover_drive_ctrl;
  localparam int RDIV = 260;
  localparam int BCYC = 200;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   md [4];
  int   c2 [2];
  int   c4 [4];

  always #5 clk = ~clk;

  rover_drive_ctrl_if #(.N_CH(2), .SENSE_W(3)) if2 ();
  rover_drive_ctrl_if #(.N_CH(4), .SENSE_W(3)) if4 ();

  assign if4.enable = if2.enable;
  assign if4.induct = if2.induct;
  assign if4.proxim = if2.proxim;

  rover_drive_ctrl #(.N_CH(2), .SIDE_MASK(2'b10), .RAMP_DIV(RDIV), .BRAKE_CYC(BCYC))
    dut2 (.clk(clk), .rst_n(rst_n), .io(if2.slave));
  rover_drive_ctrl #(.N_CH(4), .SIDE_MASK(4'b1010), .RAMP_DIV(RDIV), .BRAKE_CYC(BCYC))
    dut4 (.clk(clk), .rst_n(rst_n), .io(if4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_io(input string tag, input int st, input logic [1:0] pat);
    chk({tag, "_state2"}, 32'(if2.state), st);
    chk({tag, "_state4"}, 32'(if4.state), st);
    chk({tag, "_in2"}, 32'(if2.motor_in), 32'({2{pat}}));
    chk({tag, "_in4"}, 32'(if4.motor_in), 32'({4{pat}}));
  endtask

  task automatic chk_en0(input string tag);
    chk({tag, "_en2"}, 32'(if2.motor_en), 32'd0);
    chk({tag, "_en4"}, 32'(if4.motor_en), 32'd0);
  endtask

  // Steering rule: left = base + err*gain, right = base - err*gain, clamped to 0..255
  function automatic int tgt(input int ind, input int ch);
    int e, t;
    e = ind - 4;
    t = (ch % 2 == 0) ? 160 + e * 24 : 160 - e * 24;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t;
  endfunction

  // High-time over one full PWM period equals the duty in force
  task automatic measure();
    for (int i = 0; i < 2; i++) c2[i] = 0;
    for (int i = 0; i < 4; i++) c4[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) c2[i] += int'(if2.motor_en[i]);
      for (int i = 0; i < 4; i++) c4[i] += int'(if4.motor_en[i]);
    end
  endtask

  task automatic ramp_to(input string tag, input int ind);
    int t [4];
    int n, g, k;
    if2.induct = 3'(ind);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      t[i] = tgt(ind, i);
      g = (t[i] > md[i]) ? t[i] - md[i] : md[i] - t[i];
      k = (g + 7) / 8;
      if (k > n) n = k;
    end
    cyc((n + 1) * RDIV + 4);
    measure();
    for (int i = 0; i < 2; i++) chk($sformatf("%s_duty2_ch%0d", tag, i), c2[i], t[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_duty4_ch%0d", tag, i), c4[i], t[i]);
    chk_io(tag, 1, 2'b10);
    for (int i = 0; i < 4; i++) md[i] = t[i];
  endtask

  initial begin
    int r;
    for (int i = 0; i < 4; i++) md[i] = 0;
    rst_n = 1'b0;
    if2.enable = 1'b0;
    if2.induct = 3'd0;
    if2.proxim = 1'b0;
    cyc(3);
    chk_io("reset", 0, 2'b00);
    chk_en0("reset");
    rst_n = 1'b1;
    cyc(2);
    chk_io("idle", 0, 2'b00);

    // centred cruise ramps from 0 to 160
    if2.enable = 1'b1;
    if2.induct = 3'd4;
    cyc(2);
    chk_io("t1_run", 1, 2'b10);
    cyc(8 * RDIV);
    measure();
    chk("t1_mid_ch0", 32'(c2[0] > 0 && c2[0] < 160), 32'd1);
    chk("t1_mid_ch1", 32'(c4[3] > 0 && c4[3] < 160), 32'd1);
    ramp_to("t1", 4);

    // steering both ways, no overshoot while ramping
    if2.induct = 3'd7;
    cyc(3 * RDIV);
    measure();
    chk("t2_mid_left", 32'(c2[0] >= 160 && c2[0] <= 232), 32'd1);
    chk("t2_mid_right", 32'(c2[1] >= 88 && c2[1] <= 160), 32'd1);
    ramp_to("t2a", 7);
    ramp_to("t2b", 1);

    repeat (2) begin
      r = int'($urandom_range(7, 1));
      ramp_to("rnd", r);
    end

    // proximity pulse during RUN
    ramp_to("t3pre", 4);
    if2.proxim = 1'b1;
    cyc(2);
    chk_io("t3_sync", 1, 2'b10);
    cyc(1);
    chk_io("t3_brake", 3, 2'b11);
    chk_en0("t3_brake");
    cyc(1);
    if2.proxim = 1'b0;
    cyc(BCYC - 2);
    chk_io("t3_hold", 3, 2'b11);
    chk_en0("t3_hold");
    cyc(1);
    chk_io("t3_idle", 0, 2'b00);
    cyc(1);
    chk_io("t3_rerun", 1, 2'b10);
    for (int i = 0; i < 4; i++) md[i] = 0;
    measure();
    chk("t3_restart2", 32'(c2[0] <= 16 && c2[1] <= 16), 32'd1);
    chk("t3_restart4", 32'(c4[2] <= 16 && c4[3] <= 16), 32'd1);
    ramp_to("t3post", 4);

    // proximity held past the brake time
    if2.proxim = 1'b1;
    cyc(3);
    chk_io("t4_brake", 3, 2'b11);
    cyc(BCYC + 40);
    chk_io("t4_hold", 3, 2'b11);
    chk_en0("t4_hold");
    if2.proxim = 1'b0;
    cyc(2);
    chk_io("t4_still", 3, 2'b11);
    cyc(1);
    chk_io("t4_idle", 0, 2'b00);
    for (int i = 0; i < 4; i++) md[i] = 0;
    ramp_to("t4post", 4);

    // line lost: ramp down 8 per tick, then coast, then resume
    if2.induct = 3'd0;
    cyc(2);
    chk_io("t5_lost", 2, 2'b10);
    cyc(15 * RDIV);
    measure();
    chk("t5_step2", 32'(c2[0] >= 24 && c2[0] <= 48), 32'd1);
    chk("t5_step4", 32'(c4[3] >= 24 && c4[3] <= 48), 32'd1);
    chk_io("t5_mid", 2, 2'b10);
    cyc(6 * RDIV);
    chk_io("t5_zero", 2, 2'b00);
    chk_en0("t5_zero");
    if2.induct = 3'd4;
    cyc(2);
    chk_io("t5_resume", 1, 2'b10);
    for (int i = 0; i < 4; i++) md[i] = 0;
    ramp_to("t5post", 4);

    // asynchronous reset mid-ramp and mid-brake
    if2.induct = 3'd7;
    cyc(2 * RDIV);
    rst_n = 1'b0;
    #1;
    chk_io("t6_rst_ramp", 0, 2'b00);
    chk_en0("t6_rst_ramp");
    cyc(2);
    if2.induct = 3'd4;
    rst_n = 1'b1;
    cyc(2);
    chk_io("t6_run", 1, 2'b10);
    if2.proxim = 1'b1;
    cyc(3);
    chk_io("t6_brake", 3, 2'b11);
    cyc(20);
    rst_n = 1'b0;
    #1;
    chk_io("t6_rst_brake", 0, 2'b00);
    chk_en0("t6_rst_brake");
    if2.proxim = 1'b0;
    if2.enable = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk_io("t6_after", 0, 2'b00);
    chk_en0("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
